// File: rtl/jt51_regwr_sched.sv
// jt51_regwr_sched: schedules register writes from a CPU FIFO and a sequencer
// port into the jt51 register file, one write at a time.
// Ports:
//   clk, rst_n, cen                 - clock, async active-low reset, clock enable
//   cpu_we/cpu_addr/cpu_din         - CPU write into a 4-entry FIFO; cpu_full when full
//   seq_req/seq_addr/seq_din        - sequencer request; seq_ack pulses on grant
//   reg_busy                        - register file busy flag
//   d_in/op/ch, up_*                - per-register update strobe with data/operator/channel
//   glb_we/glb_addr/glb_din         - one-cycle write pulse for global registers
//   tmo_err/tmo_clr                 - sticky busy-handshake timeout flag and its clear
`timescale 1ns/1ps
module jt51_regwr_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic       cpu_full,
  input  logic       seq_req,
  input  logic [7:0] seq_addr,
  input  logic [7:0] seq_din,
  output logic       seq_ack,
  input  logic       reg_busy,
  output logic [7:0] d_in,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       glb_we,
  output logic [7:0] glb_addr,
  output logic [7:0] glb_din,
  output logic       tmo_err,
  input  logic       tmo_clr
);

  localparam int unsigned AW         = 8;
  localparam int unsigned DW         = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PW         = 2;
  localparam int unsigned CW         = 3;
  localparam int unsigned TW         = 6;
  localparam int unsigned NUP        = 11;

  localparam int unsigned UP_RL    = 0;
  localparam int unsigned UP_KC    = 1;
  localparam int unsigned UP_KF    = 2;
  localparam int unsigned UP_PMS   = 3;
  localparam int unsigned UP_DT1   = 4;
  localparam int unsigned UP_TL    = 5;
  localparam int unsigned UP_KS    = 6;
  localparam int unsigned UP_AMSEN = 7;
  localparam int unsigned UP_DT2   = 8;
  localparam int unsigned UP_D1L   = 9;
  localparam int unsigned UP_KEYON = 10;

  // The counter reaches 63 on the edge where it leaves this value.
  localparam logic [TW-1:0] TMO_LAST = TW'(62);

  typedef enum logic [2:0] {IDLE, ARB, ISSUE, HOLD, GLB} state_t;

  state_t            state;
  logic [AW+DW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              rr_pri;   // 1: sequencer wins the next tie
  logic [TW-1:0]     tmo_cnt;
  logic [NUP-1:0]    up_vec;

  logic              push;
  logic              pop;
  logic              cpu_rdy;
  logic              sel_seq;
  logic [AW-1:0]     ent_addr;
  logic [DW-1:0]     ent_din;
  logic [NUP-1:0]    ent_up;
  logic              ent_glb;
  logic [1:0]        ent_op;
  logic [2:0]        ent_ch;

  // Address to update-strobe decode; all-zero means a global register.
  function automatic logic [NUP-1:0] decode_up(input logic [AW-1:0] a);
    logic [NUP-1:0] v;
    v = '0;
    if (a == 8'h08) begin
      v[UP_KEYON] = 1'b1;
    end else begin
      case (a[7:5])
        3'd1: begin
          case (a[4:3])
            2'd0: v[UP_RL]  = 1'b1;
            2'd1: v[UP_KC]  = 1'b1;
            2'd2: v[UP_KF]  = 1'b1;
            2'd3: v[UP_PMS] = 1'b1;
          endcase
        end
        3'd2:    v[UP_DT1]   = 1'b1;
        3'd3:    v[UP_TL]    = 1'b1;
        3'd4:    v[UP_KS]    = 1'b1;
        3'd5:    v[UP_AMSEN] = 1'b1;
        3'd6:    v[UP_DT2]   = 1'b1;
        3'd7:    v[UP_D1L]   = 1'b1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  assign cpu_full = count[2];
  assign cpu_rdy  = (count != '0);
  assign push     = cpu_we && !cpu_full;

  // Round-robin: sequencer wins when alone or when it holds priority.
  assign sel_seq  = seq_req && (!cpu_rdy || rr_pri);
  assign pop      = cen && (state == ARB) && cpu_rdy && !sel_seq;

  assign ent_addr = sel_seq ? seq_addr : fifo_mem[rd_ptr][AW+DW-1:DW];
  assign ent_din  = sel_seq ? seq_din  : fifo_mem[rd_ptr][DW-1:0];
  assign ent_up   = decode_up(ent_addr);
  assign ent_glb  = (ent_up == '0);

  // Operator/channel fields: keyon takes the channel from the data byte.
  always_comb begin
    ent_op = 2'd0;
    ent_ch = ent_addr[2:0];
    if (ent_up[UP_KEYON]) begin
      ent_ch = ent_din[2:0];
    end else if (ent_addr[7:6] != 2'b00) begin
      ent_op = ent_addr[4:3];
    end
  end

  // FIFO storage, data only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cpu_addr, cpu_din};
    end
  end

  // FIFO pointers, arbitration FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_pri   <= 1'b0;
      tmo_cnt  <= '0;
      up_vec   <= '0;
      seq_ack  <= 1'b0;
      glb_we   <= 1'b0;
      glb_addr <= '0;
      glb_din  <= '0;
      d_in     <= '0;
      op       <= '0;
      ch       <= '0;
      tmo_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      // A timeout later in this block overrides the clear.
      if (tmo_clr) tmo_err <= 1'b0;

      if (cen) begin
        seq_ack <= 1'b0;
        glb_we  <= 1'b0;
        case (state)
          IDLE: begin
            if (cpu_rdy || seq_req) state <= ARB;
          end
          ARB: begin
            if (cpu_rdy || seq_req) begin
              rr_pri  <= !sel_seq;
              seq_ack <= sel_seq;
              tmo_cnt <= '0;
              if (ent_glb) begin
                glb_we   <= 1'b1;
                glb_addr <= ent_addr;
                glb_din  <= ent_din;
                state    <= GLB;
              end else begin
                up_vec <= ent_up;
                d_in   <= ent_din;
                op     <= ent_op;
                ch     <= ent_ch;
                state  <= ISSUE;
              end
            end else begin
              state <= IDLE;
            end
          end
          ISSUE: begin
            if (reg_busy) begin
              state <= HOLD;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
              if (tmo_cnt == TMO_LAST) begin
                up_vec  <= '0;
                tmo_err <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          HOLD: begin
            if (!reg_busy) begin
              up_vec <= '0;
              state  <= IDLE;
            end
          end
          GLB: begin
            state <= IDLE;
          end
          default: begin
            up_vec <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

  assign up_rl    = up_vec[UP_RL];
  assign up_kc    = up_vec[UP_KC];
  assign up_kf    = up_vec[UP_KF];
  assign up_pms   = up_vec[UP_PMS];
  assign up_dt1   = up_vec[UP_DT1];
  assign up_tl    = up_vec[UP_TL];
  assign up_ks    = up_vec[UP_KS];
  assign up_amsen = up_vec[UP_AMSEN];
  assign up_dt2   = up_vec[UP_DT2];
  assign up_d1l   = up_vec[UP_D1L];
  assign up_keyon = up_vec[UP_KEYON];

endmodule

// File: tb/tb_jt51_regwr_sched.sv
// Directed testbench for jt51_regwr_sched.
`timescale 1ns/1ps
module tb_jt51_regwr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_full;
  logic       seq_req = 1'b0;
  logic [7:0] seq_addr = '0;
  logic [7:0] seq_din = '0;
  logic       seq_ack;
  logic       reg_busy = 1'b0;
  logic [7:0] d_in;
  logic [1:0] op;
  logic [2:0] ch;
  logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl;
  logic       up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
  logic       glb_we;
  logic [7:0] glb_addr;
  logic [7:0] glb_din;
  logic       tmo_err;
  logic       tmo_clr = 1'b0;
  logic [10:0] ups;

  int total = 0;
  int bad = 0;

  jt51_regwr_sched dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_full(cpu_full),
    .seq_req(seq_req), .seq_addr(seq_addr), .seq_din(seq_din), .seq_ack(seq_ack),
    .reg_busy(reg_busy), .d_in(d_in), .op(op), .ch(ch),
    .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
    .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
    .up_dt2(up_dt2), .up_d1l(up_d1l), .up_keyon(up_keyon),
    .glb_we(glb_we), .glb_addr(glb_addr), .glb_din(glb_din),
    .tmo_err(tmo_err), .tmo_clr(tmo_clr)
  );

  assign ups = {up_keyon, up_d1l, up_dt2, up_amsen, up_ks, up_tl,
                up_dt1, up_pms, up_kf, up_kc, up_rl};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    tick(1);
    cpu_we   = 1'b0;
  endtask

  task automatic busy_pulse();
    reg_busy = 1'b1;
    tick(1);
    reg_busy = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    total++; if (ups !== 11'h000) begin bad++; $display("FAIL rst_ups: got %h want %h", ups, 11'h000); end
    total++; if (cpu_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", cpu_full); end
    total++; if (seq_ack !== 1'b0 || glb_we !== 1'b0 || tmo_err !== 1'b0) begin bad++;
      $display("FAIL rst_flags: got ack=%b glb_we=%b tmo=%b want 000", seq_ack, glb_we, tmo_err); end
    total++; if (d_in !== 8'h00 || op !== 2'd0 || ch !== 3'd0 || glb_addr !== 8'h00 || glb_din !== 8'h00) begin bad++;
      $display("FAIL rst_data: got d_in=%h op=%h ch=%h ga=%h gd=%h want zeros", d_in, op, ch, glb_addr, glb_din); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_kc();
    cpu_write(8'h28, 8'h4A);
    tick(2);
    total++; if (ups !== 11'h002) begin bad++; $display("FAIL kc_strobe: got %h want %h", ups, 11'h002); end
    total++; if (d_in !== 8'h4A || op !== 2'd0 || ch !== 3'd0) begin bad++;
      $display("FAIL kc_fields: got d_in=%h op=%0d ch=%0d want 4a 0 0", d_in, op, ch); end
    reg_busy = 1'b1;
    tick(3);
    total++; if (ups !== 11'h002 || d_in !== 8'h4A) begin bad++;
      $display("FAIL kc_hold: got ups=%h d_in=%h want 002 4a", ups, d_in); end
    reg_busy = 1'b0;
    tick(1);
    total++; if (ups !== 11'h000) begin bad++; $display("FAIL kc_release: got %h want %h", ups, 11'h000); end
    tick(5);
    total++; if (ups !== 11'h000 || cpu_full !== 1'b0) begin bad++;
      $display("FAIL kc_empty: got ups=%h full=%b want 000 0", ups, cpu_full); end
  endtask

  task automatic test_timeout();
    cpu_write(8'h6D, 8'h7F);
    tick(2);
    total++; if (ups !== 11'h020 || op !== 2'd1 || ch !== 3'd5 || d_in !== 8'h7F) begin bad++;
      $display("FAIL tl_issue: got ups=%h op=%0d ch=%0d d_in=%h want 020 1 5 7f", ups, op, ch, d_in); end
    tick(62);
    total++; if (ups !== 11'h020 || tmo_err !== 1'b0) begin bad++;
      $display("FAIL tl_before_tmo: got ups=%h tmo=%b want 020 0", ups, tmo_err); end
    tick(1);
    total++; if (ups !== 11'h000 || tmo_err !== 1'b1) begin bad++;
      $display("FAIL tl_tmo: got ups=%h tmo=%b want 000 1", ups, tmo_err); end
    tick(3);
    total++; if (tmo_err !== 1'b1 || ups !== 11'h000) begin bad++;
      $display("FAIL tmo_sticky: got tmo=%b ups=%h want 1 000", tmo_err, ups); end
    tmo_clr = 1'b1;
    tick(1);
    tmo_clr = 1'b0;
    total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clr: got %b want 0", tmo_err); end
  endtask

  task automatic test_clr_vs_tmo();
    cpu_write(8'h30, 8'h11);
    tick(2);
    total++; if (ups !== 11'h004) begin bad++; $display("FAIL kf_issue: got %h want %h", ups, 11'h004); end
    tick(62);
    tmo_clr = 1'b1;
    tick(1);
    tmo_clr = 1'b0;
    total++; if (tmo_err !== 1'b1 || ups !== 11'h000) begin bad++;
      $display("FAIL clr_vs_tmo: got tmo=%b ups=%h want 1 000", tmo_err, ups); end
    tmo_clr = 1'b1;
    tick(1);
    tmo_clr = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic found;
    cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write(8'h20 + 8'(i), 8'(i + 1));
      if (i == 2) begin
        total++; if (cpu_full !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", cpu_full); end
      end
      if (i >= 3) begin
        total++; if (cpu_full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1 (write %0d)", cpu_full, i); end
      end
    end
    cen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        tick(1);
        if (ups !== 11'h000) found = 1'b1;
      end
      total++; if (!found || ups !== 11'h001 || ch !== 3'(i) || d_in !== 8'(i + 1)) begin bad++;
        $display("FAIL fifo_order%0d: got ups=%h ch=%0d d_in=%h want 001 %0d %h", i, ups, ch, d_in, i, i + 1); end
      busy_pulse();
      total++; if (ups !== 11'h000) begin bad++; $display("FAIL fifo_drop%0d: got %h want 000", i, ups); end
    end
    tick(8);
    total++; if (ups !== 11'h000 || cpu_full !== 1'b0) begin bad++;
      $display("FAIL fifth_dropped: got ups=%h full=%b want 000 0", ups, cpu_full); end
  endtask

  task automatic test_arb();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    cen = 1'b0;
    cpu_write(8'h08, 8'h7B);
    seq_addr = 8'hE3;
    seq_din  = 8'h5C;
    seq_req  = 1'b1;
    cen = 1'b1;
    tick(2);
    total++; if (ups !== 11'h400 || ch !== 3'd3 || op !== 2'd0 || d_in !== 8'h7B) begin bad++;
      $display("FAIL keyon_first: got ups=%h ch=%0d op=%0d d_in=%h want 400 3 0 7b", ups, ch, op, d_in); end
    total++; if (seq_ack !== 1'b0) begin bad++; $display("FAIL ack_early: got %b want 0", seq_ack); end
    busy_pulse();
    tick(2);
    total++; if (ups !== 11'h200 || op !== 2'd0 || ch !== 3'd3 || d_in !== 8'h5C) begin bad++;
      $display("FAIL d1l_second: got ups=%h op=%0d ch=%0d d_in=%h want 200 0 3 5c", ups, op, ch, d_in); end
    total++; if (seq_ack !== 1'b1) begin bad++; $display("FAIL ack_pulse: got %b want 1", seq_ack); end
    seq_req = 1'b0;
    tick(1);
    total++; if (seq_ack !== 1'b0) begin bad++; $display("FAIL ack_once: got %b want 0", seq_ack); end
    busy_pulse();
  endtask

  task automatic test_glb();
    cpu_write(8'h14, 8'h15);
    tick(2);
    total++; if (glb_we !== 1'b1 || glb_addr !== 8'h14 || glb_din !== 8'h15) begin bad++;
      $display("FAIL glb_pulse: got we=%b a=%h d=%h want 1 14 15", glb_we, glb_addr, glb_din); end
    total++; if (ups !== 11'h000) begin bad++; $display("FAIL glb_nostrobe: got %h want 000", ups); end
    tick(1);
    total++; if (glb_we !== 1'b0 || ups !== 11'h000) begin bad++;
      $display("FAIL glb_end: got we=%b ups=%h want 0 000", glb_we, ups); end
  endtask

  task automatic test_cen();
    cen = 1'b0;
    cpu_write(8'h38, 8'h66);
    tick(6);
    total++; if (ups !== 11'h000) begin bad++; $display("FAIL cen_stall: got %h want 000", ups); end
    cen = 1'b1;
    tick(2);
    total++; if (ups !== 11'h008 || ch !== 3'd0 || d_in !== 8'h66) begin bad++;
      $display("FAIL cen_issue: got ups=%h ch=%0d d_in=%h want 008 0 66", ups, ch, d_in); end
    busy_pulse();
  endtask

  task automatic test_push_pop();
    cen = 1'b0;
    cpu_write(8'h29, 8'hA1);
    cen = 1'b1;
    tick(1);
    cpu_write(8'h2A, 8'hA2);
    total++; if (ups !== 11'h002 || d_in !== 8'hA1 || ch !== 3'd1 || cpu_full !== 1'b0) begin bad++;
      $display("FAIL pp_first: got ups=%h d_in=%h ch=%0d full=%b want 002 a1 1 0", ups, d_in, ch, cpu_full); end
    busy_pulse();
    tick(2);
    total++; if (ups !== 11'h002 || d_in !== 8'hA2 || ch !== 3'd2) begin bad++;
      $display("FAIL pp_second: got ups=%h d_in=%h ch=%0d want 002 a2 2", ups, d_in, ch); end
    busy_pulse();
    tick(4);
    total++; if (ups !== 11'h000) begin bad++; $display("FAIL pp_count: got %h want 000", ups); end
  endtask

  task automatic test_reset_hold();
    cpu_write(8'h40, 8'h33);
    tick(2);
    reg_busy = 1'b1;
    tick(1);
    total++; if (ups !== 11'h010) begin bad++; $display("FAIL dt1_hold: got %h want %h", ups, 11'h010); end
    cpu_write(8'h48, 8'h01);
    rst_n = 1'b0;
    #1;
    total++; if (ups !== 11'h000 || d_in !== 8'h00 || cpu_full !== 1'b0) begin bad++;
      $display("FAIL rst_hold: got ups=%h d_in=%h full=%b want 000 00 0", ups, d_in, cpu_full); end
    tick(1);
    rst_n = 1'b1;
    reg_busy = 1'b0;
    tick(6);
    total++; if (ups !== 11'h000 || glb_we !== 1'b0) begin bad++;
      $display("FAIL rst_empty: got ups=%h glb_we=%b want 000 0", ups, glb_we); end
  endtask

  initial begin
    test_reset();
    test_kc();
    test_timeout();
    test_clr_vs_tmo();
    test_fifo_full();
    test_arb();
    test_glb();
    test_cen();
    test_push_pop();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
